// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for a single-port memory: CPU port (C) and loader/debug port (L).
// Define ARB_CPU_PRIORITY_EN for fixed CPU priority; default is round-robin.
module mem_port_arbiter #(
    parameter int AW      = 5,
    parameter int DW      = 8,
    parameter int MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_req,
    input  logic          c_rw,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_done,
    output logic [DW-1:0] c_rdata,
    input  logic          l_req,
    input  logic          l_rw,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    output logic          l_gnt,
    output logic          l_done,
    output logic [DW-1:0] l_rdata,
    output logic          mem_rd,
    output logic          mem_rw,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          arb_busy
);

    localparam int CW = $clog2(MEM_LAT + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t        state_reg;
    logic [CW-1:0] cnt_reg;
    logic          owner_reg;      // 0 = C, 1 = L
    logic [1:0]    gnt_reg;        // bit 0 = C, bit 1 = L
    logic [1:0]    done_reg;
    logic [DW-1:0] c_rdata_reg;
    logic [DW-1:0] l_rdata_reg;
    logic          mem_rd_reg;
    logic          mem_rw_reg;
    logic [AW-1:0] mem_addr_reg;
    logic [DW-1:0] mem_wdata_reg;
    logic          busy_reg;
`ifndef ARB_CPU_PRIORITY_EN
    logic          last_reg;       // port served most recently
`endif

    logic          pick_l;
    logic          sel_rw;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    always_comb begin
        pick_l = 1'b0;
`ifdef ARB_CPU_PRIORITY_EN
        pick_l = l_req && !c_req;
`else
        // On a tie the port that was not served last wins.
        pick_l = l_req && (!c_req || !last_reg);
`endif
        sel_rw    = c_rw;
        sel_addr  = c_addr;
        sel_wdata = c_wdata;
        if (pick_l) begin
            sel_rw    = l_rw;
            sel_addr  = l_addr;
            sel_wdata = l_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            owner_reg     <= 1'b0;
            gnt_reg       <= '0;
            done_reg      <= '0;
            c_rdata_reg   <= '0;
            l_rdata_reg   <= '0;
            mem_rd_reg    <= 1'b0;
            mem_rw_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            busy_reg      <= 1'b0;
`ifndef ARB_CPU_PRIORITY_EN
            last_reg      <= 1'b1;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (c_req || l_req) begin
                        state_reg     <= ACCESS;
                        cnt_reg       <= CNT_LOAD;
                        owner_reg     <= pick_l;
                        gnt_reg       <= pick_l ? 2'b10 : 2'b01;
                        mem_rd_reg    <= !sel_rw;
                        mem_rw_reg    <= sel_rw;
                        mem_addr_reg  <= sel_addr;
                        mem_wdata_reg <= sel_wdata;
                        busy_reg      <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end else begin
                        // Read data is valid in the last strobe cycle.
                        if (mem_rd_reg) begin
                            if (owner_reg) l_rdata_reg <= mem_rdata;
                            else           c_rdata_reg <= mem_rdata;
                        end
                        state_reg     <= DONE;
                        done_reg      <= gnt_reg;
                        mem_rd_reg    <= 1'b0;
                        mem_rw_reg    <= 1'b0;
                        mem_addr_reg  <= '0;
                        mem_wdata_reg <= '0;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    gnt_reg   <= '0;
                    done_reg  <= '0;
                    busy_reg  <= 1'b0;
`ifndef ARB_CPU_PRIORITY_EN
                    last_reg  <= owner_reg;
`endif
                end
                default: begin
                    state_reg <= IDLE;
                    gnt_reg   <= '0;
                    done_reg  <= '0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign c_gnt     = gnt_reg[0];
    assign l_gnt     = gnt_reg[1];
    assign c_done    = done_reg[0];
    assign l_done    = done_reg[1];
    assign c_rdata   = c_rdata_reg;
    assign l_rdata   = l_rdata_reg;
    assign mem_rd    = mem_rd_reg;
    assign mem_rw    = mem_rw_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign arb_busy  = busy_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, hand-written corner sequences,
// random traffic against a transaction-level timing model, and a MEM_LAT=1 instance.
module tb_mem_port_arbiter;
    localparam int AW  = 5;
    localparam int DW  = 8;
    localparam int LAT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          c_req, c_rw, l_req, l_rw;
    logic [AW-1:0] c_addr, l_addr;
    logic [DW-1:0] c_wdata, l_wdata;
    logic          c_gnt, c_done, l_gnt, l_done;
    logic [DW-1:0] c_rdata, l_rdata;
    logic          mem_rd, mem_rw, arb_busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    logic [DW-1:0] mem_img [32];
    assign mem_rdata = mem_img[mem_addr];

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_rw(c_rw), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_done(c_done), .c_rdata(c_rdata),
        .l_req(l_req), .l_rw(l_rw), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_gnt(l_gnt), .l_done(l_done), .l_rdata(l_rdata),
        .mem_rd(mem_rd), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .arb_busy(arb_busy)
    );

    // Second instance with single-cycle access time.
    logic          s_c_req, s_c_gnt, s_c_done, s_l_gnt, s_l_done;
    logic [AW-1:0] s_c_addr, s_mem_addr;
    logic [DW-1:0] s_c_rdata, s_l_rdata, s_mem_wdata, s_mem_rdata;
    logic          s_mem_rd, s_mem_rw, s_busy;
    assign s_mem_rdata = mem_img[s_mem_addr];

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1)) dut1 (
        .clk(clk), .reset(reset),
        .c_req(s_c_req), .c_rw(1'b0), .c_addr(s_c_addr), .c_wdata(8'h00),
        .c_gnt(s_c_gnt), .c_done(s_c_done), .c_rdata(s_c_rdata),
        .l_req(1'b0), .l_rw(1'b0), .l_addr(5'h00), .l_wdata(8'h00),
        .l_gnt(s_l_gnt), .l_done(s_l_done), .l_rdata(s_l_rdata),
        .mem_rd(s_mem_rd), .mem_rw(s_mem_rw), .mem_addr(s_mem_addr),
        .mem_wdata(s_mem_wdata), .mem_rdata(s_mem_rdata), .arb_busy(s_busy)
    );

    typedef struct packed {
        logic          c_gnt, c_done;
        logic [DW-1:0] c_rdata;
        logic          l_gnt, l_done;
        logic [DW-1:0] l_rdata;
        logic          mem_rd, mem_rw;
        logic [AW-1:0] mem_addr;
        logic [DW-1:0] mem_wdata;
        logic          arb_busy;
    } outs_t;

    typedef struct {
        logic          rst_n, c_req, c_rw;
        logic [AW-1:0] c_addr;
        logic [DW-1:0] c_wdata;
        logic          l_req, l_rw;
        logic [AW-1:0] l_addr;
        logic [DW-1:0] l_wdata;
        bit            bus;     // compare mem_addr/mem_wdata in this cycle
        outs_t         exp;
    } vec_t;

    int n_cmp  = 0;
    int n_fail = 0;

    function automatic outs_t sample();
        outs_t o;
        o = '{c_gnt, c_done, c_rdata, l_gnt, l_done, l_rdata,
              mem_rd, mem_rw, mem_addr, mem_wdata, arb_busy};
        return o;
    endfunction

    function automatic outs_t mk(logic cg, logic cd, logic [7:0] crd, logic lg, logic ld,
                                 logic [7:0] lrd, logic rd, logic rw, logic [4:0] ad,
                                 logic [7:0] wd, logic bz);
        outs_t o;
        o = '{cg, cd, crd, lg, ld, lrd, rd, rw, ad, wd, bz};
        return o;
    endfunction

    task automatic check(input string name, input outs_t exp, input bit bus);
        outs_t got;
        outs_t e;
        got = sample();
        e   = exp;
        if (!bus) begin
            got.mem_addr = '0; got.mem_wdata = '0;
            e.mem_addr   = '0; e.mem_wdata   = '0;
        end
        n_cmp++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL %s: outputs %h, required %h", name, got, e);
        end
    endtask

    task automatic check_val(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        c_req = 0; c_rw = 0; c_addr = '0; c_wdata = '0;
        l_req = 0; l_rw = 0; l_addr = '0; l_wdata = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle_inputs();
        step();
        step();
        reset = 1'b1;
    endtask

    // Random-traffic requester state and transaction-level model state.
    bit            rq [2];
    logic          rwv [2];
    logic [AW-1:0] ad [2];
    logic [DW-1:0] wd [2];
    int            gap [2];
    int            m_start, m_own, m_last;
    logic          m_rw;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd;
    logic [DW-1:0] m_rd [2];

    vec_t vecs [9];
    int   order [4];
    int   when [4];
    int   exp_order [4];

    initial begin
        for (int i = 0; i < 32; i++) mem_img[i] = 8'($urandom_range(0, 255));
        mem_img[3] = 8'hA5;
        mem_img[4] = 8'h5A;
        mem_img[2] = 8'hC3;
        s_c_req  = 1'b0;
        s_c_addr = '0;
        reset    = 1'b0;
        idle_inputs();
        step();

        // ---------------- vector table: reset, CPU read, loader write ----------------
        vecs[0] = '{0, 0, 0, 5'h00, 8'h00, 0, 0, 5'h00, 8'h00, 1, mk(0,0,8'h00,0,0,8'h00,0,0,5'h00,8'h00,0)};
        vecs[1] = '{1, 1, 0, 5'h03, 8'h00, 0, 0, 5'h00, 8'h00, 1, mk(1,0,8'h00,0,0,8'h00,1,0,5'h03,8'h00,1)};
        vecs[2] = '{1, 1, 0, 5'h03, 8'h00, 0, 0, 5'h00, 8'h00, 1, mk(1,0,8'h00,0,0,8'h00,1,0,5'h03,8'h00,1)};
        vecs[3] = '{1, 1, 0, 5'h03, 8'h00, 0, 0, 5'h00, 8'h00, 0, mk(1,1,8'hA5,0,0,8'h00,0,0,5'h00,8'h00,1)};
        vecs[4] = '{1, 0, 0, 5'h00, 8'h00, 0, 0, 5'h00, 8'h00, 0, mk(0,0,8'hA5,0,0,8'h00,0,0,5'h00,8'h00,0)};
        vecs[5] = '{1, 0, 0, 5'h00, 8'h00, 1, 1, 5'h1F, 8'h3C, 1, mk(0,0,8'hA5,1,0,8'h00,0,1,5'h1F,8'h3C,1)};
        vecs[6] = '{1, 0, 0, 5'h00, 8'h00, 1, 1, 5'h1F, 8'h3C, 1, mk(0,0,8'hA5,1,0,8'h00,0,1,5'h1F,8'h3C,1)};
        vecs[7] = '{1, 0, 0, 5'h00, 8'h00, 1, 1, 5'h1F, 8'h3C, 0, mk(0,0,8'hA5,1,1,8'h00,0,0,5'h00,8'h00,1)};
        vecs[8] = '{1, 0, 0, 5'h00, 8'h00, 0, 0, 5'h00, 8'h00, 0, mk(0,0,8'hA5,0,0,8'h00,0,0,5'h00,8'h00,0)};
        for (int i = 0; i < 9; i++) begin
            reset   = vecs[i].rst_n;
            c_req   = vecs[i].c_req;  c_rw = vecs[i].c_rw;
            c_addr  = vecs[i].c_addr; c_wdata = vecs[i].c_wdata;
            l_req   = vecs[i].l_req;  l_rw = vecs[i].l_rw;
            l_addr  = vecs[i].l_addr; l_wdata = vecs[i].l_wdata;
            step();
            check($sformatf("vec%0d", i), vecs[i].exp, vecs[i].bus);
            $display("vec %0d: c_req=%0b l_req=%0b -> gnt=%0b%0b done=%0b%0b rd=%0b rw=%0b addr=%h",
                     i, c_req, l_req, l_gnt, c_gnt, l_done, c_done, mem_rd, mem_rw, mem_addr);
        end

        // ---------------- simultaneous requests held high ----------------
        do_reset();
`ifdef ARB_CPU_PRIORITY_EN
        exp_order = '{0, 0, 0, 1};
`else
        exp_order = '{0, 1, 0, 1};
`endif
        for (int i = 0; i < 4; i++) begin order[i] = -1; when[i] = -1; end
        c_req = 1; c_rw = 0; c_addr = 5'h03;
        l_req = 1; l_rw = 0; l_addr = 5'h04;
        begin
            int got;
            got = 0;
            for (int cy = 0; cy < 80 && got < 4; cy++) begin
                step();
                if (c_done || l_done) begin
                    order[got] = c_done ? 0 : 1;
                    when[got]  = cy;
                    $display("arb: done #%0d for port %s at cycle %0d", got, c_done ? "C" : "L", cy);
                    got++;
`ifdef ARB_CPU_PRIORITY_EN
                    if (got == 3) c_req = 0;
`endif
                end
            end
            check_val("arb_done_count", got, 4);
        end
        for (int i = 0; i < 4; i++) check_val($sformatf("arb_order%0d", i), order[i], exp_order[i]);
        for (int i = 1; i < 4; i++) check_val($sformatf("arb_period%0d", i), when[i] - when[i-1], LAT + 2);
        idle_inputs();
        step();

        // ---------------- address change during ACCESS is ignored ----------------
        do_reset();
        c_req = 1; c_rw = 0; c_addr = 5'h03;
        step();
        check_val("latch_addr_k0", int'(mem_addr), 3);
        c_addr = 5'h07;
        step();
        check_val("latch_addr_k1", int'(mem_addr), 3);
        check_val("latch_rd_k1", int'(mem_rd), 1);
        step();
        check_val("latch_done", int'(c_done), 1);
        check_val("latch_rdata", int'(c_rdata), 8'hA5);
        $display("latch: mem_addr held 03, c_rdata=%h", c_rdata);
        idle_inputs();
        step();

        // ---------------- reset during first ACCESS cycle ----------------
        do_reset();
        c_req = 1; c_rw = 0; c_addr = 5'h03;
        step();
        check_val("abort_gnt_before", int'(c_gnt), 1);
        reset = 1'b0;
        step();
        check("abort_outputs", '0, 1);
        reset = 1'b1;
        c_req = 0;
        step();
        check_val("abort_no_done", int'(c_done) + int'(arb_busy), 0);
        c_req = 1; c_addr = 5'h04;
        begin
            int n;
            n = 0;
            for (int cy = 1; cy <= 12 && n == 0; cy++) begin
                step();
                if (c_done) n = cy;
            end
            check_val("abort_fresh_latency", n, LAT + 1);
            check_val("abort_fresh_rdata", int'(c_rdata), 8'h5A);
            $display("abort: fresh read done after %0d cycles, c_rdata=%h", n, c_rdata);
        end
        idle_inputs();
        step();

        // ---------------- MEM_LAT=1 instance ----------------
        s_c_req = 1; s_c_addr = 5'h02;
        begin
            int n1, n2, strobes;
            n1 = 0; n2 = 0; strobes = 0;
            for (int cy = 1; cy <= 12 && n1 == 0; cy++) begin
                step();
                if (s_mem_rd) strobes++;
                if (s_c_done) n1 = cy;
            end
            check_val("lat1_latency", n1, 2);
            check_val("lat1_strobe_cycles", strobes, 1);
            check_val("lat1_rdata", int'(s_c_rdata), 8'hC3);
            for (int cy = 1; cy <= 12 && n2 == 0; cy++) begin
                step();
                if (s_c_done) n2 = cy;
            end
            check_val("lat1_period", n2, 3);
            $display("lat1: done after %0d cycles, next after %0d", n1, n2);
        end
        s_c_req = 0;
        step();

        // ---------------- random traffic vs. transaction model ----------------
        do_reset();
        m_start = -100; m_own = 0; m_last = 1; m_rw = 0; m_addr = '0; m_wd = '0;
        m_rd[0] = '0; m_rd[1] = '0;
        for (int p = 0; p < 2; p++) begin
            rq[p] = 0; rwv[p] = 0; ad[p] = '0; wd[p] = '0;
            gap[p] = $urandom_range(0, 3);
        end
        for (int n = 0; n < 600; n++) begin
            outs_t e;
            int    k;
            bit    dn [2];
            c_req = rq[0]; c_rw = rwv[0]; c_addr = ad[0]; c_wdata = wd[0];
            l_req = rq[1]; l_rw = rwv[1]; l_addr = ad[1]; l_wdata = wd[1];
            @(posedge clk);
            // An access occupies LAT strobe cycles, one done cycle and one idle cycle.
            if (n >= m_start + LAT + 2 && (rq[0] || rq[1])) begin
`ifdef ARB_CPU_PRIORITY_EN
                m_own = rq[0] ? 0 : 1;
`else
                m_own = (rq[0] && rq[1]) ? 1 - m_last : (rq[0] ? 0 : 1);
`endif
                m_last  = m_own;
                m_start = n;
                m_rw    = rwv[m_own];
                m_addr  = ad[m_own];
                m_wd    = wd[m_own];
            end
            #1;
            k = n - m_start;
            e = '0;
            if (k == LAT && !m_rw) m_rd[m_own] = mem_img[m_addr];
            if (k <= LAT) begin
                e.arb_busy = 1;
                if (m_own == 0) e.c_gnt = 1; else e.l_gnt = 1;
            end
            if (k < LAT) begin
                e.mem_rd = !m_rw; e.mem_rw = m_rw;
                e.mem_addr = m_addr; e.mem_wdata = m_wd;
            end
            if (k == LAT) begin
                if (m_own == 0) e.c_done = 1; else e.l_done = 1;
            end
            e.c_rdata = m_rd[0];
            e.l_rdata = m_rd[1];
            check($sformatf("rand_cyc%0d", n), e, k < LAT);
            if (e.c_done || e.l_done)
                $display("rand: cycle %0d port %s %s addr=%h data=%h", n, e.c_done ? "C" : "L",
                         m_rw ? "write" : "read", m_addr, m_rw ? m_wd : m_rd[m_own]);
            dn[0] = e.c_done;
            dn[1] = e.l_done;
            for (int p = 0; p < 2; p++) begin
                if (rq[p] && dn[p]) begin
                    rq[p]  = 0;
                    gap[p] = $urandom_range(0, 3);
                end
                if (!rq[p]) begin
                    if (gap[p] == 0) begin
                        rq[p]  = 1;
                        rwv[p] = 1'($urandom_range(0, 1));
                        ad[p]  = 5'($urandom_range(0, 31));
                        wd[p]  = 8'($urandom_range(0, 255));
                    end else begin
                        gap[p]--;
                    end
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
